mdu_iter: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage pipeline. It replaces the single-cycle 64-bit EX-stage multiplier and adds signed/unsigned division. It computes over multiple cycles while the core stalls on `busy`. It sits beside the ALU in EX, takes forwarded operands, and feeds HI/LO to the MFHI/MFLO path.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_iter_if.sv | 27 ++
 rtl/mdu_divstep.sv | 22 ++
 rtl/mdu_iter.sv | 151 +++++++++++++++
 tb/tb_mdu_iter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and counter sizing shared
// by the iterative multiply/divide unit and its bench.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } mdu_state_e;

   function automatic int cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: EX-stage request and HI/LO result bundle
// between the core (master) and the multiply/divide unit (slave).
interface mdu_iter_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step
// on {rem, quot} against a fixed divisor.
module mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quot,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_n,
   output logic [WIDTH-1:0] quot_n
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   // rem < divisor holds between steps, so bit WIDTH is a true sign
   assign rem_sh = {rem, quot[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, divisor};
   assign rem_n  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quot_n = {quot[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/DIV unit with architectural HI/LO.
// Define MDU_EARLY_TERM_EN to stop multiplies once the multiplier drains.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   mdu_iter_if.slave mdu
);

   localparam int              CW    = cnt_w(WIDTH);
   localparam int              W2    = 2 * WIDTH;
   localparam logic [CW-1:0]   STEPS = CW'(WIDTH);

   mdu_state_e       state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [W2-1:0]    mcand, mcand_n;
   logic [W2-1:0]    prod, prod_n;
   logic [WIDTH-1:0] mplier, mplier_n;
   logic [WIDTH-1:0] hi, hi_n, lo, lo_n;
   logic             is_div, is_div_n;
   logic             neg_p, neg_p_n;
   logic             neg_r, neg_r_n;
   logic             done, done_n;

   logic [WIDTH-1:0] ds_rem, ds_quot;
   logic [WIDTH-1:0] a_mag, b_mag, mplier_sh;
   logic             op_sgn, op_md, op_mthi, op_mtlo;
   logic             a_neg, b_neg, last;

   assign op_md     = ~mdu.op[2];
   assign op_mthi   = (mdu.op == MDU_MTHI);
   assign op_mtlo   = (mdu.op == MDU_MTLO);
   assign op_sgn    = (mdu.op == MDU_MULT) || (mdu.op == MDU_DIV);
   assign a_neg     = op_sgn & mdu.a[WIDTH-1];
   assign b_neg     = op_sgn & mdu.b[WIDTH-1];
   assign a_mag     = a_neg ? -mdu.a : mdu.a;
   assign b_mag     = b_neg ? -mdu.b : mdu.b;
   assign mplier_sh = mplier >> 1;

   // divide reuses prod as {rem, quot} and mplier as the divisor
   mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem     (prod[W2-1:WIDTH]),
      .quot    (prod[WIDTH-1:0]),
      .divisor (mplier),
      .rem_n   (ds_rem),
      .quot_n  (ds_quot)
   );

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mcand_n  = mcand;
      prod_n   = prod;
      mplier_n = mplier;
      hi_n     = hi;
      lo_n     = lo;
      is_div_n = is_div;
      neg_p_n  = neg_p;
      neg_r_n  = neg_r;
      done_n   = 1'b0;
      last     = 1'b0;
      if (mdu.flush) begin
         state_n = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (mdu.start) begin
                  unique case (1'b1)
                     op_mthi: hi_n = mdu.a;
                     op_mtlo: lo_n = mdu.a;
                     op_md: begin
                        state_n  = S_CALC;
                        is_div_n = mdu.op[1];
                        neg_p_n  = a_neg ^ b_neg;
                        neg_r_n  = a_neg;
                        cnt_n    = '0;
                        mcand_n  = {{WIDTH{1'b0}}, a_mag};
                        mplier_n = b_mag;
                        prod_n   = mdu.op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                     end
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
               cnt_n = cnt + 1'b1;
               if (is_div) begin
                  prod_n = {ds_rem, ds_quot};
               end else begin
                  if (mplier[0]) prod_n = prod + mcand;
                  mcand_n  = mcand << 1;
                  mplier_n = mplier_sh;
               end
               last = (cnt_n == STEPS);
`ifdef MDU_EARLY_TERM_EN
               if (!is_div && (mplier_sh == '0)) last = 1'b1;
`endif
               if (last) state_n = S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  lo_n = neg_p ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
                  hi_n = neg_r ? -prod[W2-1:WIDTH] : prod[W2-1:WIDTH];
               end else begin
                  {hi_n, lo_n} = neg_p ? -prod : prod;
               end
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mcand  <= '0;
         prod   <= '0;
         mplier <= '0;
         hi     <= '0;
         lo     <= '0;
         is_div <= 1'b0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mcand  <= mcand_n;
         prod   <= prod_n;
         mplier <= mplier_n;
         hi     <= hi_n;
         lo     <= lo_n;
         is_div <= is_div_n;
         neg_p  <= neg_p_n;
         neg_r  <= neg_r_n;
         done   <= done_n;
      end
   end

   assign mdu.busy = (state != S_IDLE);
   assign mdu.done = done;
   assign mdu.hi   = hi;
   assign mdu.lo   = lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random ops against an arithmetic
// HI/LO model, latency, done pulse, flush and reset checks.
module tb_mdu_iter;
   import mdu_pkg::*;

   localparam int W = 32;
`ifdef MDU_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   int           n_chk = 0;
   int           n_pass = 0;
   logic [W-1:0] m_hi, m_lo;

   mdu_iter_if #(.WIDTH(W)) mif ();

   mdu_iter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .mdu (mif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] ref_hilo(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MDU_MULT:  return 64'(sa * sb);
         MDU_MULTU: return {32'd0, a} * {32'd0, b};
         MDU_DIV: begin
            if (b == '0) return {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == '0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int exp_busy(input logic [2:0] op,
                                   input logic [W-1:0] b);
      logic [W-1:0] m;
      int           et;
      bit           is_mul;
      is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
      m  = (op == MDU_MULT && b[W-1]) ? -b : b;
      et = 1;
      for (int i = 0; i < W; i++) if (m[i]) et = i + 1;
      return (EARLY && is_mul) ? et + 1 : W + 1;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      logic [63:0] r;
      int          cyc;
      bit          early;
      @(negedge clk);
      mif.start = 1'b1;
      mif.op    = op;
      mif.a     = a;
      mif.b     = b;
      @(negedge clk);
      mif.start = 1'b0;
      cyc   = 0;
      early = 1'b0;
      while (mif.busy && cyc < 100) begin
         cyc++;
         if (mif.done) early = 1'b1;
         @(negedge clk);
      end
      r    = ref_hilo(op, a, b);
      m_hi = r[63:32];
      m_lo = r[31:0];
      check("busy_cycles", 64'(cyc), 64'(exp_busy(op, b)));
      check("done_early", 64'(early), 64'd0);
      check("done_pulse", 64'(mif.done), 64'd1);
      check("hi", 64'(mif.hi), 64'(m_hi));
      check("lo", 64'(mif.lo), 64'(m_lo));
      @(negedge clk);
      check("done_clear", 64'(mif.done), 64'd0);
   endtask

   task automatic mt(input logic [2:0] op, input logic [W-1:0] a);
      @(negedge clk);
      mif.start = 1'b1;
      mif.op    = op;
      mif.a     = a;
      mif.b     = '0;
      @(negedge clk);
      mif.start = 1'b0;
      if (op == MDU_MTHI) m_hi = a;
      if (op == MDU_MTLO) m_lo = a;
      check("mt_busy", 64'(mif.busy), 64'd0);
      check("mt_done", 64'(mif.done), 64'd0);
      check("mt_hi", 64'(mif.hi), 64'(m_hi));
      check("mt_lo", 64'(mif.lo), 64'(m_lo));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int cyc;
      rst       = 1'b1;
      mif.start = 1'b0;
      mif.op    = '0;
      mif.a     = '0;
      mif.b     = '0;
      mif.flush = 1'b0;
      m_hi      = '0;
      m_lo      = '0;
      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(mif.busy), 64'd0);
      check("rst_done", 64'(mif.done), 64'd0);
      check("rst_hi", 64'(mif.hi), 64'd0);
      check("rst_lo", 64'(mif.lo), 64'd0);
      rst = 1'b1;

      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("tp_multu_hi", 64'(mif.hi), 64'h0000_0000_FFFF_FFFE);
      check("tp_multu_lo", 64'(mif.lo), 64'h0000_0000_0000_0001);
      run_op(MDU_MULT, -32'sd3, 32'd5);
      check("tp_mult_lo", 64'(mif.lo), 64'h0000_0000_FFFF_FFF1);
      run_op(MDU_DIV, -32'sd7, 32'd2);
      check("tp_div_lo", 64'(mif.lo), 64'h0000_0000_FFFF_FFFD);
      check("tp_div_hi", 64'(mif.hi), 64'h0000_0000_FFFF_FFFF);
      run_op(MDU_DIVU, 32'd9, 32'd0);
      run_op(MDU_DIV, -32'sd4, 32'd0);
      check("tp_div0_lo", 64'(mif.lo), 64'd1);
      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check("tp_divmin_lo", 64'(mif.lo), 64'h0000_0000_8000_0000);
      run_op(MDU_MULTU, 32'd5, 32'd3);
      run_op(MDU_MULTU, 32'd7, 32'd0);
      mt(3'd6, 32'hDEAD_BEEF);

      // flush mid-CALC leaves seeded HI/LO alone
      mt(MDU_MTHI, 32'h1234);
      mt(MDU_MTLO, 32'h5678);
      @(negedge clk);
      mif.start = 1'b1;
      mif.op    = MDU_MULTU;
      mif.a     = 32'hFFFF_FFFF;
      mif.b     = 32'hFFFF_FFFF;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (9) @(negedge clk);
      check("flush_pre_busy", 64'(mif.busy), 64'd1);
      mif.flush = 1'b1;
      @(negedge clk);
      mif.flush = 1'b0;
      check("flush_busy", 64'(mif.busy), 64'd0);
      check("flush_done", 64'(mif.done), 64'd0);
      check("flush_hi", 64'(mif.hi), 64'h1234);
      check("flush_lo", 64'(mif.lo), 64'h5678);
      @(negedge clk);
      check("flush_done2", 64'(mif.done), 64'd0);

      // flush together with start drops the start
      @(negedge clk);
      mif.start = 1'b1;
      mif.flush = 1'b1;
      mif.op    = MDU_MTHI;
      mif.a     = 32'hFFFF;
      @(negedge clk);
      mif.start = 1'b0;
      mif.flush = 1'b0;
      check("fs_busy", 64'(mif.busy), 64'd0);
      check("fs_hi", 64'(mif.hi), 64'(m_hi));

      // MTHI while busy is ignored
      @(negedge clk);
      mif.start = 1'b1;
      mif.op    = MDU_MULTU;
      mif.a     = 32'h1_0000;
      mif.b     = 32'h1_0000;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (3) @(negedge clk);
      mif.start = 1'b1;
      mif.op    = MDU_MTHI;
      mif.a     = 32'hDEAD;
      @(negedge clk);
      mif.start = 1'b0;
      cyc = 0;
      while (mif.busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      m_hi = 32'd1;
      m_lo = 32'd0;
      check("bz_hi", 64'(mif.hi), 64'(m_hi));
      check("bz_lo", 64'(mif.lo), 64'(m_lo));

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0)
            mt(3'($urandom_range(4, 7)), W'($urandom));
         run_op(3'($urandom_range(0, 3)), pick(), pick());
      end

      // reset mid-op
      @(negedge clk);
      mif.start = 1'b1;
      mif.op    = MDU_DIV;
      mif.a     = 32'h1234_5678;
      mif.b     = 32'd7;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rmid_busy", 64'(mif.busy), 64'd0);
      check("rmid_done", 64'(mif.done), 64'd0);
      check("rmid_hi", 64'(mif.hi), 64'd0);
      check("rmid_lo", 64'(mif.lo), 64'd0);
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      rst = 1'b1;
      run_op(MDU_DIVU, 32'd100, 32'd7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
